// File: rtl/gsim_param.sv
// Fixed-point Gauss-Seidel solver for a symmetric banded system with a 7-point stencil.
// Loads N integer b samples, runs ITER in-place sweeps, then streams x out over valid/ready.
module gsim_param #(
   parameter int N    = 16,
   parameter int B_W  = 16,
   parameter int X_W  = 32,
   parameter int ITER = 256
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_en,
   input  logic [B_W-1:0] b_in,
   output logic           in_ready,
   output logic           busy,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [X_W-1:0] x_out
);

   // Handshakes: a sample moves on a rising edge with in_en && in_ready; an output
   // element moves on a rising edge with out_valid && out_ready, and x_out/out_valid
   // stay put until that edge.

   localparam int W  = X_W + 8;
   localparam int IW = $clog2(N + 1);
   localparam int SW = $clog2(ITER + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_ITER = 2'd2;
   localparam logic [1:0] S_OUT  = 2'd3;

   localparam logic [IW-1:0] N_C    = IW'(N);
   localparam logic [IW-1:0] LAST_I = IW'(N - 1);
   localparam logic [SW-1:0] LAST_S = SW'(ITER - 1);

   localparam logic signed [W-1:0] C6    = W'(6);
   localparam logic signed [W-1:0] C13   = W'(13);
   localparam logic signed [W-1:0] C20   = W'(20);
   localparam logic signed [W-1:0] X_MAX = signed'({{(W - X_W + 1){1'b0}}, {(X_W - 1){1'b1}}});
   localparam logic signed [W-1:0] X_MIN = signed'({{(W - X_W + 1){1'b1}}, {(X_W - 1){1'b0}}});

   logic [1:0]     state;
   logic [IW-1:0]  cnt;
   logic [IW-1:0]  idx;
   logic [IW-1:0]  k;
   logic [SW-1:0]  sweep;
   logic [X_W-1:0] x     [N];
   logic [B_W-1:0] b_mem [N];

   int                    ii;
   logic signed [W-1:0]   xe;
   logic signed [W-1:0]   num;
   logic signed [W-1:0]   quo;
   logic [X_W-1:0]        x_new;

   // Neighbours outside 0..N-1 simply never match a j, so they contribute zero.
   always_comb begin
      ii    = 32'(idx);
      xe    = '0;
      num   = '0;
      for (int j = 0; j < N; j++) begin
         xe = signed'({{(W - X_W){x[j][X_W-1]}}, x[j]});
         if (j == ii)
            num = num + signed'({{(W - B_W - 16){b_mem[j][B_W-1]}}, b_mem[j], 16'h0000});
         if (j == ii - 1 || j == ii + 1)
            num = num + C13 * xe;
         if (j == ii - 2 || j == ii + 2)
            num = num - C6 * xe;
         if (j == ii - 3 || j == ii + 3)
            num = num + xe;
      end
      quo = num / C20;
      if (quo > X_MAX)
         x_new = X_MAX[X_W-1:0];
      else if (quo < X_MIN)
         x_new = X_MIN[X_W-1:0];
      else
         x_new = quo[X_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         idx       <= '0;
         sweep     <= '0;
         k         <= '0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         x_out     <= '0;
         for (int j = 0; j < N; j++)
            x[j] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_en) begin
                  b_mem[0] <= b_in;
                  cnt      <= IW'(1);
                  in_ready <= (N > 1);
                  state    <= S_LOAD;
                  for (int j = 0; j < N; j++)
                     x[j] <= '0;
               end
            end

            S_LOAD: begin
               // One settling cycle after the last sample keeps the latency at N*ITER+1.
               if (cnt == N_C) begin
                  state    <= S_ITER;
                  busy     <= 1'b1;
                  idx      <= '0;
                  sweep    <= '0;
               end else if (in_en) begin
                  for (int j = 0; j < N; j++)
                     if (j == 32'(cnt))
                        b_mem[j] <= b_in;
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST_I)
                     in_ready <= 1'b0;
               end
            end

            S_ITER: begin
               for (int j = 0; j < N; j++)
                  if (j == ii)
                     x[j] <= x_new;
               if (idx == LAST_I) begin
                  idx <= '0;
                  if (sweep == LAST_S) begin
                     state     <= S_OUT;
                     busy      <= 1'b0;
                     out_valid <= 1'b1;
                     k         <= '0;
                     // With N == 1 the final update lands on x[0] this same edge.
                     if (idx == '0)
                        x_out <= x_new;
                     else
                        x_out <= x[0];
                  end else begin
                     sweep <= sweep + 1'b1;
                  end
               end else begin
                  idx <= idx + 1'b1;
               end
            end

            S_OUT: begin
               if (out_ready) begin
                  if (k == LAST_I) begin
                     state     <= S_IDLE;
                     out_valid <= 1'b0;
                     in_ready  <= 1'b1;
                     k         <= '0;
                     cnt       <= '0;
                     x_out     <= '0;
                  end else begin
                     k <= k + 1'b1;
                     for (int j = 0; j < N; j++)
                        if (j == 32'(k) + 1)
                           x_out <= x[j];
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gsim_param.sv
// Bench for gsim_param: a default-size instance (N=16, ITER=256) and an N=1, ITER=1 instance,
// checked against a behavioural Gauss-Seidel model through expected-value queues.
module tb_gsim_param;

   localparam int NB     = 16;
   localparam int ITER_C = 256;

   logic        clk = 1'b0;
   logic        reset;

   logic        in_en16, in_ready16, busy16, out_valid16, out_ready16;
   logic [15:0] b_in16;
   logic [31:0] x_out16;

   logic        in_en1, in_ready1, busy1, out_valid1, out_ready1;
   logic [15:0] b_in1;
   logic [31:0] x_out1;

   int          errors = 0;
   int          checks = 0;
   int          cyc    = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp1_q[$];
   int          cur_b[NB];
   logic [31:0] got[NB];
   int          coef[4];
   int          aw[4];

   gsim_param #(.N(NB), .B_W(16), .X_W(32), .ITER(ITER_C)) dut16 (
      .clk(clk), .reset(reset), .in_en(in_en16), .b_in(b_in16),
      .in_ready(in_ready16), .busy(busy16), .out_valid(out_valid16),
      .out_ready(out_ready16), .x_out(x_out16)
   );

   gsim_param #(.N(1), .B_W(16), .X_W(32), .ITER(1)) dut1 (
      .clk(clk), .reset(reset), .in_en(in_en1), .b_in(b_in1),
      .in_ready(in_ready1), .busy(busy1), .out_valid(out_valid1),
      .out_ready(out_ready1), .x_out(x_out1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference Gauss-Seidel on the banded matrix, exact integer arithmetic.
   task automatic model16();
      longint xm[NB];
      longint num, q;
      for (int i = 0; i < NB; i++) xm[i] = 0;
      for (int s = 0; s < ITER_C; s++) begin
         for (int i = 0; i < NB; i++) begin
            num = longint'(cur_b[i]) * 65536;
            for (int d = 1; d <= 3; d++) begin
               if (i - d >= 0) num += coef[d] * xm[i - d];
               if (i + d < NB) num += coef[d] * xm[i + d];
            end
            q = num / 20;
            if (q > 64'sd2147483647) q = 64'sd2147483647;
            if (q < -64'sd2147483648) q = -64'sd2147483648;
            xm[i] = q;
         end
      end
      for (int i = 0; i < NB; i++) exp_q.push_back(32'(xm[i]));
   endtask

   task automatic send16(input int max_gap);
      int g;
      for (int i = 0; i < NB; i++) begin
         g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         repeat (g) tick();
         chk("in_ready_load", in_ready16, 1);
         in_en16 = 1'b1;
         b_in16  = 16'(cur_b[i]);
         tick();
         in_en16 = 1'b0;
      end
   endtask

   task automatic wait16(input bit pulses);
      int lat, busy_n, rdy_bad;
      lat = 0; busy_n = 0; rdy_bad = 0;
      while (!out_valid16 && lat < 5000) begin
         if (pulses && (lat % 500) == 7) begin
            in_en16 = 1'b1;
            b_in16  = 16'($urandom);
         end else begin
            in_en16 = 1'b0;
         end
         tick();
         lat++;
         if (busy16) busy_n++;
         if (busy16 && in_ready16) rdy_bad++;
      end
      in_en16 = 1'b0;
      chk("latency16", lat, NB * ITER_C + 1);
      chk("busy_cycles", busy_n, NB * ITER_C);
      chk("in_ready_low_in_iter", rdy_bad, 0);
   endtask

   task automatic drain16(input int stall_k, input int stall_len);
      int k, budget, held;
      logic [31:0] e;
      k = 0; budget = 0; held = 0;
      while (k < NB && budget < 200) begin
         budget++;
         if (out_valid16) begin
            if (k == stall_k && held < stall_len) begin
               out_ready16 = 1'b0;
               chk("stall_x_held", x_out16, (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF);
               held++;
            end else begin
               out_ready16 = 1'b1;
               chk("scoreboard_nonempty", exp_q.size() > 0, 1);
               e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
               chk("x_out16", x_out16, e);
               got[k] = x_out16;
               k++;
            end
         end
         tick();
      end
      out_ready16 = 1'b1;
      chk("handshakes", k, NB);
      chk("stall_cycles", held, stall_len);
      chk("valid_drop_after_last", out_valid16, 0);
      chk("in_ready_after_last", in_ready16, 1);
      chk("scoreboard_empty", exp_q.size(), 0);
   endtask

   task automatic residual16();
      real tot, r, xf;
      int  d;
      tot = 0.0;
      for (int i = 0; i < NB; i++) begin
         r = -real'(cur_b[i]);
         for (int j = 0; j < NB; j++) begin
            d = (i > j) ? i - j : j - i;
            if (d <= 3) begin
               xf = real'(int'($signed(got[j]))) / 65536.0;
               r  = r + real'(aw[d]) * xf;
            end
         end
         tot = tot + r * r;
      end
      chk("residual_below_0p3", longint'(tot < 0.3), 1);
   endtask

   task automatic run16(input int max_gap, input bit pulses, input int stall_k,
                        input int stall_len, input bit resid);
      model16();
      send16(max_gap);
      wait16(pulses);
      drain16(stall_k, stall_len);
      if (resid) residual16();
   endtask

   task automatic run1(input int bval);
      int lat;
      logic [31:0] e;
      exp1_q.push_back(32'(longint'(bval) * 65536 / 20));
      chk("n1_in_ready", in_ready1, 1);
      in_en1 = 1'b1;
      b_in1  = 16'(bval);
      tick();
      in_en1 = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < 20) begin
         tick();
         lat++;
      end
      chk("n1_latency", lat, 2);
      e = exp1_q.pop_front();
      chk("n1_x_out", x_out1, e);
      tick();
      chk("n1_valid_drop", out_valid1, 0);
   endtask

   initial begin
      int stale;
      coef = '{0, 13, -6, 1};
      aw   = '{20, -13, 6, -1};
      reset = 1'b1;
      in_en16 = 1'b1; b_in16 = 16'h7777; out_ready16 = 1'b1;
      in_en1  = 1'b1; b_in1  = 16'h0011; out_ready1  = 1'b1;
      repeat (3) tick();
      chk("rst_out_valid16", out_valid16, 0);
      chk("rst_busy16", busy16, 0);
      chk("rst_in_ready16", in_ready16, 1);
      chk("rst_x_out16", x_out16, 0);
      chk("rst_out_valid1", out_valid1, 0);
      chk("rst_in_ready1", in_ready1, 1);
      in_en16 = 1'b0; in_en1 = 1'b0;
      reset = 1'b0;
      tick();

      run1(20);
      run1(-20);
      run1(-32768);
      run1(32767);

      for (int i = 0; i < NB; i++) cur_b[i] = 0;
      run16(0, 1'b0, -1, 0, 1'b0);

      cur_b = '{1000, -2000, 3000, 500, -700, 1234, -4321, 2500,
                0, 42, -42, 800, -800, 100, 200, -300};
      run16(0, 1'b0, 3, 5, 1'b1);
      run16(3, 1'b1, -1, 0, 1'b1);

      for (int i = 0; i < NB; i++) cur_b[i] = int'($urandom_range(2000, 0)) - 1000;
      send16(0);
      repeat (1 + 10 * NB) tick();
      chk("mid_iter_busy", busy16, 1);
      reset = 1'b1;
      in_en16 = 1'b1; b_in16 = 16'h1234;
      tick();
      reset = 1'b0;
      in_en16 = 1'b0;
      chk("post_rst_out_valid", out_valid16, 0);
      chk("post_rst_busy", busy16, 0);
      chk("post_rst_in_ready", in_ready16, 1);
      chk("post_rst_x_out", x_out16, 0);
      stale = 0;
      repeat (30) begin
         tick();
         if (out_valid16 || busy16) stale++;
      end
      chk("no_stale_after_reset", stale, 0);

      for (int i = 0; i < NB; i++) cur_b[i] = 0;
      run16(0, 1'b1, -1, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
